// File: rtl/shader_dispatch.sv
// shader_dispatch: initiator side of the shader_unit start/done handshake.
// For each triangle of a batch it reads nine fp32 vertex words from vertex
// memory, presents them on sh_p1/sh_p2/sh_p3, starts the shader, waits for
// completion and writes the returned colour to the colour buffer.
// Optional feature: define DISPATCH_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles (shader is reset, colour forced to all ones, flag set).
module shader_dispatch #(
    parameter int ADDR_W  = 10,
    parameter int TRI_W   = 8,
    parameter int COLOR_W = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    areset_n,
    input  logic                    go,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [TRI_W-1:0]        tri_count,
    output logic                    busy,
    output logic                    finished,
    output logic                    timeout_flag,
    output logic                    vmem_re,
    output logic [ADDR_W-1:0]       vmem_addr,
    input  logic [31:0]             vmem_rdata,
    output logic [2:0][31:0]        sh_p1,
    output logic [2:0][31:0]        sh_p2,
    output logic [2:0][31:0]        sh_p3,
    output logic                    sh_start,
    output logic                    sh_sreset,
    input  logic [COLOR_W-1:0]      sh_color,
    input  logic                    sh_done,
    output logic                    col_we,
    output logic [TRI_W-1:0]        col_addr,
    output logic [COLOR_W-1:0]      col_data
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
`ifdef DISPATCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EMPTY = 3'd1,
        S_FETCH = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_WRITE = 3'd5
    } state_t;

    state_t             state_r;
    logic [TRI_W-1:0]   tri_idx_r;
    logic [TRI_W-1:0]   tri_cnt_r;
    logic [ADDR_W-1:0]  ptr_r;        // next vertex word address (running pointer)
    logic [3:0]         fetch_cnt_r;  // FETCH cycle number 0..9
    logic [TMR_W-1:0]   wait_cnt_r;   // cycles spent in WAIT

    logic [TRI_W-1:0]   next_idx_s;
    logic               last_tri_s;
    logic               tmo_hit_s;

    assign next_idx_s = tri_idx_r + TRI_W'(1);
    assign last_tri_s = (next_idx_s == tri_cnt_r);
    assign tmo_hit_s  = TMO_EN && (wait_cnt_r == TMR_LAST);

    // Batch sequencer: state, counters and every registered output.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_r      <= S_IDLE;
            tri_idx_r    <= '0;
            tri_cnt_r    <= '0;
            ptr_r        <= '0;
            fetch_cnt_r  <= 4'd0;
            wait_cnt_r   <= '0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            timeout_flag <= 1'b0;
            vmem_re      <= 1'b0;
            vmem_addr    <= '0;
            sh_p1        <= '0;
            sh_p2        <= '0;
            sh_p3        <= '0;
            sh_start     <= 1'b0;
            sh_sreset    <= 1'b0;
            col_we       <= 1'b0;
            col_addr     <= '0;
            col_data     <= '0;
        end else begin
            // pulse outputs default low; states raise them for one cycle
            sh_start  <= 1'b0;
            sh_sreset <= 1'b0;
            finished  <= 1'b0;
            col_we    <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (go) begin
                        tri_cnt_r    <= tri_count;
                        tri_idx_r    <= '0;
                        timeout_flag <= 1'b0;
                        busy         <= 1'b1;
                        sh_sreset    <= 1'b1;
                        if (tri_count == '0) begin
                            state_r <= S_EMPTY;
                        end else begin
                            state_r     <= S_FETCH;
                            vmem_re     <= 1'b1;
                            vmem_addr   <= base_addr;
                            ptr_r       <= base_addr + ADDR_W'(1);
                            fetch_cnt_r <= 4'd0;
                        end
                    end
                end
                S_EMPTY: begin
                    finished <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= S_IDLE;
                end
                S_FETCH: begin
                    // word k arrives one cycle after its read, i.e. on FETCH cycle k+1
                    case (fetch_cnt_r)
                        4'd1:    sh_p1[0] <= vmem_rdata;
                        4'd2:    sh_p1[1] <= vmem_rdata;
                        4'd3:    sh_p1[2] <= vmem_rdata;
                        4'd4:    sh_p2[0] <= vmem_rdata;
                        4'd5:    sh_p2[1] <= vmem_rdata;
                        4'd6:    sh_p2[2] <= vmem_rdata;
                        4'd7:    sh_p3[0] <= vmem_rdata;
                        4'd8:    sh_p3[1] <= vmem_rdata;
                        4'd9:    sh_p3[2] <= vmem_rdata;
                        default: ;
                    endcase
                    fetch_cnt_r <= fetch_cnt_r + 4'd1;
                    if (fetch_cnt_r < 4'd8) begin
                        vmem_re   <= 1'b1;
                        vmem_addr <= ptr_r;
                        ptr_r     <= ptr_r + ADDR_W'(1);
                    end else begin
                        vmem_re   <= 1'b0;
                        vmem_addr <= '0;
                    end
                    if (fetch_cnt_r == 4'd9) begin
                        state_r  <= S_ISSUE;
                        sh_start <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // sh_done is stale here (still reflects the previous job)
                    state_r    <= S_WAIT;
                    wait_cnt_r <= '0;
                end
                S_WAIT: begin
                    if (sh_done) begin
                        col_data <= sh_color;
                        col_we   <= 1'b1;
                        col_addr <= tri_idx_r;
                        state_r  <= S_WRITE;
                    end else if (tmo_hit_s) begin
                        col_data     <= {COLOR_W{1'b1}};
                        col_we       <= 1'b1;
                        col_addr     <= tri_idx_r;
                        sh_sreset    <= 1'b1;
                        timeout_flag <= 1'b1;
                        state_r      <= S_WRITE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TMR_W'(1);
                    end
                end
                S_WRITE: begin
                    tri_idx_r <= next_idx_s;
                    if (last_tri_s) begin
                        finished <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= S_IDLE;
                    end else begin
                        state_r     <= S_FETCH;
                        vmem_re     <= 1'b1;
                        vmem_addr   <= ptr_r;
                        ptr_r       <= ptr_r + ADDR_W'(1);
                        fetch_cnt_r <= 4'd0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    vmem_re <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shader_dispatch.sv
// Self-checking bench for shader_dispatch: vertex memory and shader models,
// output monitor, and a per-batch reference computed from address arithmetic.
module tb_shader_dispatch;

    localparam int ADDR_W  = 10;
    localparam int TRI_W   = 8;
    localparam int COLOR_W = 4;
    localparam int TIMEOUT = 16;
    localparam int MEM_N   = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                areset_n = 1'b0;
    logic                go = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [TRI_W-1:0]    tri_count = '0;
    logic                busy, finished, timeout_flag, vmem_re;
    logic [ADDR_W-1:0]   vmem_addr;
    logic [31:0]         vmem_rdata = 32'h0;
    logic [2:0][31:0]    sh_p1, sh_p2, sh_p3;
    logic                sh_start, sh_sreset;
    logic [COLOR_W-1:0]  sh_color = '0;
    logic                sh_done = 1'b0;
    logic                col_we;
    logic [TRI_W-1:0]    col_addr;
    logic [COLOR_W-1:0]  col_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    shader_dispatch #(.ADDR_W(ADDR_W), .TRI_W(TRI_W), .COLOR_W(COLOR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .areset_n(areset_n), .go(go), .base_addr(base_addr), .tri_count(tri_count),
        .busy(busy), .finished(finished), .timeout_flag(timeout_flag),
        .vmem_re(vmem_re), .vmem_addr(vmem_addr), .vmem_rdata(vmem_rdata),
        .sh_p1(sh_p1), .sh_p2(sh_p2), .sh_p3(sh_p3),
        .sh_start(sh_start), .sh_sreset(sh_sreset), .sh_color(sh_color), .sh_done(sh_done),
        .col_we(col_we), .col_addr(col_addr), .col_data(col_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // vertex memory: registered read, data valid the cycle after vmem_re
    logic [31:0] mem [0:MEM_N-1];
    always @(posedge clk) if (vmem_re) vmem_rdata <= mem[vmem_addr];

    // shader model: done is a level held until the next start; sreset forces done
    int sh_lat = 1;               // cycles from start to done; 0 = never completes
    int forced_color = -1;        // -1 = random colour
    int rem = 0;
    int color_q[$];
    always @(posedge clk) begin
        if (!areset_n) begin
            sh_done <= 1'b0;
            rem     <= 0;
        end else if (sh_sreset) begin
            sh_done <= 1'b1;
            rem     <= 0;
        end else if (sh_start) begin
            sh_done <= 1'b0;
            rem     <= sh_lat;
        end else if (rem > 1) begin
            rem <= rem - 1;
        end else if (rem == 1) begin
            int c;
            c = (forced_color >= 0) ? forced_color : int'($urandom_range(0, 15));
            rem      <= 0;
            sh_done  <= 1'b1;
            sh_color <= COLOR_W'(c);
            color_q.push_back(c);
        end
    end

    // monitor of DUT activity
    bit mon_en = 1'b0;
    int rd_q[$];
    logic [95:0] p1_q[$], p2_q[$], p3_q[$];
    int start_cyc_q[$], sreset_cyc_q[$], wa_q[$], wd_q[$];
    int fin_cnt = 0;
    always @(negedge clk) begin
        if (mon_en && areset_n) begin
            if (vmem_re) rd_q.push_back(int'(vmem_addr));
            if (sh_start) begin
                p1_q.push_back(sh_p1);
                p2_q.push_back(sh_p2);
                p3_q.push_back(sh_p3);
                start_cyc_q.push_back(cyc);
            end
            if (sh_sreset) sreset_cyc_q.push_back(cyc);
            if (col_we) begin
                wa_q.push_back(int'(col_addr));
                wd_q.push_back(int'(col_data));
                if (p1_q.size() > 0) begin
                    check_val("p1_stable", sh_p1, p1_q[$]);
                    check_val("p3_stable", sh_p3, p3_q[$]);
                end
            end
            if (finished) fin_cnt++;
        end
    end

    function automatic logic [95:0] vert(input int base, input int tri_i, input int v);
        int a0;
        a0 = base + 9 * tri_i + 3 * v;
        return {mem[(a0 + 2) % MEM_N], mem[(a0 + 1) % MEM_N], mem[a0 % MEM_N]};
    endfunction

    task automatic run_batch(input int base, input int count, input int lat,
                             input bit mid_go, input bit exp_to);
        int n;
        bit seen;
        rd_q.delete(); p1_q.delete(); p2_q.delete(); p3_q.delete();
        start_cyc_q.delete(); sreset_cyc_q.delete(); wa_q.delete(); wd_q.delete();
        color_q.delete();
        fin_cnt = 0;
        sh_lat  = lat;
        mon_en  = 1'b1;
        @(negedge clk);
        base_addr = ADDR_W'(base);
        tri_count = TRI_W'(count);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        base_addr = ADDR_W'($urandom);   // must not be re-sampled mid-batch
        tri_count = TRI_W'($urandom);
        check_val("busy_ack", busy, 1);
        check_val("sreset_ack", sh_sreset, 1);
        check_val("flag_clr", timeout_flag, 0);
        seen = 1'b0;
        n = 0;
        while (n < 3000 && !seen) begin
            @(negedge clk);
            if (finished) seen = 1'b1;
            else n++;
            if (mid_go && n == 25) go = 1'b1;
            if (mid_go && n == 26) go = 1'b0;
        end
        go = 1'b0;
        check_val("finish_seen", seen, 1);
        check_val("busy_at_fin", busy, 0);
        if (count == 0) check_val("empty_latency", n, 0);
        @(negedge clk);
        check_val("fin_pulse", finished, 0);
        check_val("fin_cnt", fin_cnt, 1);
        check_val("flag_end", timeout_flag, exp_to);
        check_val("n_reads", rd_q.size(), 9 * count);
        check_val("n_starts", start_cyc_q.size(), count);
        check_val("n_writes", wa_q.size(), count);
        check_val("n_sreset", sreset_cyc_q.size(), exp_to ? count + 1 : 1);
        if (rd_q.size() == 9 * count && start_cyc_q.size() == count && wa_q.size() == count) begin
            for (int i = 0; i < count; i++) begin
                for (int k = 0; k < 9; k++)
                    check_val("vmem_addr", rd_q[9 * i + k], (base + 9 * i + k) % MEM_N);
                check_val("sh_p1", p1_q[i], vert(base, i, 0));
                check_val("sh_p2", p2_q[i], vert(base, i, 1));
                check_val("sh_p3", p3_q[i], vert(base, i, 2));
                check_val("col_addr", wa_q[i], i);
                if (exp_to) begin
                    check_val("col_data_to", wd_q[i], 15);
                    if (sreset_cyc_q.size() == count + 1)
                        check_val("to_sreset_cyc", sreset_cyc_q[i + 1] - start_cyc_q[i], TIMEOUT + 1);
                end else begin
                    check_val("col_data", wd_q[i], (i < color_q.size()) ? color_q[i] : -1);
                end
            end
        end
        repeat (3) @(negedge clk);
        check_val("idle_after", busy, 0);
        mon_en = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        for (int a = 0; a < MEM_N; a++) mem[a] = $urandom;
        for (int k = 0; k < 9; k++) mem[16 + k] = 32'h3F80_0000 + k;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_outs", {finished, timeout_flag, vmem_re, sh_start, sh_sreset, col_we}, 0);
        check_val("rst_p1", sh_p1, 0);
        check_val("rst_p3", sh_p3, 0);
        check_val("rst_addr", {vmem_addr, col_addr, col_data}, 0);
        areset_n = 1'b1;
        repeat (2) @(negedge clk);

        // empty batch
        run_batch(32'h155, 0, 3, 1'b0, 1'b0);
        // single triangle, known vertex words, colour 7 after 5 cycles
        forced_color = 7;
        run_batch(32'h010, 1, 5, 1'b0, 1'b0);
        forced_color = -1;
        // address wrap, stale done in ISSUE, go while busy
        run_batch(32'h3FA, 3, 2, 1'b1, 1'b0);
        // randomized batches
        for (int r = 0; r < 8; r++)
            run_batch(int'($urandom_range(0, MEM_N - 1)), int'($urandom_range(1, 4)),
                      int'($urandom_range(1, 6)), bit'($urandom_range(0, 1)), 1'b0);

        // asynchronous reset while waiting on the shader
        sh_lat = 0;
        @(negedge clk);
        base_addr = 10'h020;
        tri_count = 8'd2;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        seen = 1'b0;
        n = 0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            if (sh_start) seen = 1'b1;
            n++;
        end
        check_val("start_seen", seen, 1);
        repeat (5) @(negedge clk);
`ifndef DISPATCH_TIMEOUT_EN
        repeat (200) @(negedge clk);
        check_val("hang_busy", busy, 1);
        check_val("hang_flag", timeout_flag, 0);
`endif
        #2 areset_n = 1'b0;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_outs", {col_we, sh_start, vmem_re, finished}, 0);
        check_val("arst_p1", sh_p1, 0);
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        run_batch(32'h0F0, 2, 3, 1'b0, 1'b0);

`ifdef DISPATCH_TIMEOUT_EN
        // shader never completes: every triangle times out
        run_batch(32'h200, 2, 0, 1'b0, 1'b1);
        run_batch(32'h300, 1, 4, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
